// File: rtl/sys_defs_pkg.sv
// Shared rename-stage definitions: free-list sizing, port bundles and derived widths.
package sys_defs_pkg;
    localparam int C_DP_NUM    = 2;
    localparam int C_RT_NUM    = 2;
    localparam int C_PR_ENTRY  = 64;
    localparam int C_ARCH_NUM  = 32;
    localparam int C_FL_ENTRY  = C_PR_ENTRY - C_ARCH_NUM;
    localparam int C_ROB_ENTRY = 32;

    localparam int FL_IDX_W = $clog2(C_FL_ENTRY);
    localparam int PR_W     = $clog2(C_PR_ENTRY);
    localparam int ROB_W    = $clog2(C_ROB_ENTRY);
    localparam int DP_CNT_W = $clog2(C_DP_NUM + 1);
    localparam int RT_CNT_W = $clog2(C_RT_NUM + 1);

    localparam logic [PR_W-1:0] ZERO_PREG = '0;

    typedef struct packed {
        logic [DP_CNT_W-1:0]              dp_num;
        logic [C_DP_NUM-1:0]              rd_nz;
        logic [C_DP_NUM-1:0][ROB_W-1:0]   rob_idx;
    } DP_FL;

    typedef struct packed {
        logic [C_DP_NUM-1:0][PR_W-1:0]    preg;
        logic [DP_CNT_W-1:0]              avail_num;
    } FL_DP;

    typedef struct packed {
        logic [RT_CNT_W-1:0]              rt_num;
        logic [C_RT_NUM-1:0][PR_W-1:0]    told;
        logic                             rollback;
        logic [ROB_W-1:0]                 rollback_idx;
        logic                             flush;
    } ROB_FL;
endpackage

// File: rtl/fl_lane_prefix.sv
// Exclusive prefix popcount of a lane mask: each lane learns how many lower lanes are set.
module fl_lane_prefix #(
    parameter int N  = 2,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]          i_mask,
    output logic [N-1:0][CW-1:0]  o_prefix,
    output logic [CW-1:0]         o_total
);
    import sys_defs_pkg::*;

    always_comb begin
        o_total = '0;
        for (int l = 0; l < N; l++) begin
            o_prefix[l] = o_total;
            o_total     = o_total + CW'(i_mask[l]);
        end
    end
endmodule

// File: rtl/freelist_nway.sv
// N-wide circular free list of physical register tags with per-ROB snapshot rollback and flush.
module freelist_nway
    import sys_defs_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [DP_CNT_W-1:0]             dp_num_i,
    input  logic [C_DP_NUM-1:0]             dp_rd_nz_i,
    input  logic [C_DP_NUM-1:0][ROB_W-1:0]  dp_rob_idx_i,
    output logic [C_DP_NUM-1:0][PR_W-1:0]   dp_preg_o,
    output logic [DP_CNT_W-1:0]             avail_num_o,
    input  logic [RT_CNT_W-1:0]             rt_num_i,
    input  logic [C_RT_NUM-1:0][PR_W-1:0]   rt_told_i,
    input  logic                            rollback_i,
    input  logic [ROB_W-1:0]                rollback_idx_i,
    input  logic                            flush_i,
    output logic [FL_IDX_W:0]               count_o
);
    localparam int PTR_W = FL_IDX_W + 1;

    DP_FL  w_dp;
    ROB_FL w_rob;
    FL_DP  w_fl;

    logic [PR_W-1:0]  r_table [C_FL_ENTRY];
    logic [PTR_W-1:0] r_snap  [C_ROB_ENTRY];
    logic [PTR_W-1:0] r_head, r_tail, r_cmt_head;

    logic [PTR_W-1:0] w_count, w_head_nxt, w_tail_nxt, w_cmt_nxt;
    logic [C_DP_NUM-1:0]                w_dp_en, w_dp_vld;
    logic [C_DP_NUM-1:0][DP_CNT_W-1:0]  w_dp_k;
    logic [DP_CNT_W-1:0]                w_dp_tot;
    logic [C_RT_NUM-1:0]                w_rt_vld;
    logic [C_RT_NUM-1:0][RT_CNT_W-1:0]  w_rt_k;
    logic [RT_CNT_W-1:0]                w_rt_tot;
    logic                               w_dp_take;

    assign w_dp.dp_num       = dp_num_i;
    assign w_dp.rd_nz        = dp_rd_nz_i;
    assign w_dp.rob_idx      = dp_rob_idx_i;
    assign w_rob.rt_num      = rt_num_i;
    assign w_rob.told        = rt_told_i;
    assign w_rob.rollback    = rollback_i;
    assign w_rob.rollback_idx = rollback_idx_i;
    assign w_rob.flush       = flush_i;

    always_comb begin
        for (int l = 0; l < C_DP_NUM; l++) begin
            w_dp_en[l]  = DP_CNT_W'(l) < w_dp.dp_num;
            w_dp_vld[l] = w_dp_en[l] & w_dp.rd_nz[l];
        end
        for (int l = 0; l < C_RT_NUM; l++) begin
            w_rt_vld[l] = (RT_CNT_W'(l) < w_rob.rt_num) && (w_rob.told[l] != ZERO_PREG);
        end
    end

    fl_lane_prefix #(.N(C_DP_NUM), .CW(DP_CNT_W)) u_dp_prefix (
        .i_mask   (w_dp_vld),
        .o_prefix (w_dp_k),
        .o_total  (w_dp_tot)
    );

    fl_lane_prefix #(.N(C_RT_NUM), .CW(RT_CNT_W)) u_rt_prefix (
        .i_mask   (w_rt_vld),
        .o_prefix (w_rt_k),
        .o_total  (w_rt_tot)
    );

    // Grants and availability see registered pointers only; freed tags become visible next cycle.
    always_comb begin
        w_count   = r_tail - r_head;
        w_dp_take = !w_rob.flush && !w_rob.rollback;
        for (int l = 0; l < C_DP_NUM; l++) begin
            w_fl.preg[l] = w_dp_vld[l]
                         ? r_table[FL_IDX_W'(r_head + PTR_W'(w_dp_k[l]))]
                         : ZERO_PREG;
        end
        w_fl.avail_num = (w_count >= PTR_W'(C_DP_NUM)) ? DP_CNT_W'(C_DP_NUM)
                                                       : DP_CNT_W'(w_count);
        w_tail_nxt = r_tail + PTR_W'(w_rt_tot);
        w_cmt_nxt  = r_cmt_head + PTR_W'(w_rt_tot);
        if (w_rob.flush) begin
            w_head_nxt = w_cmt_nxt;
        end else if (w_rob.rollback) begin
            w_head_nxt = r_snap[w_rob.rollback_idx];
        end else begin
            w_head_nxt = r_head + PTR_W'(w_dp_tot);
        end
    end

    assign dp_preg_o   = w_fl.preg;
    assign avail_num_o = w_fl.avail_num;
    assign count_o     = w_count;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_head     <= '0;
            r_cmt_head <= '0;
            r_tail     <= PTR_W'(C_FL_ENTRY);
            for (int i = 0; i < C_FL_ENTRY; i++) begin
                r_table[i] <= PR_W'(C_ARCH_NUM + i);
            end
            for (int i = 0; i < C_ROB_ENTRY; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_cmt_head <= w_cmt_nxt;
            for (int l = 0; l < C_RT_NUM; l++) begin
                if (w_rt_vld[l]) begin
                    r_table[FL_IDX_W'(r_tail + PTR_W'(w_rt_k[l]))] <= w_rob.told[l];
                end
            end
            // Every dispatched lane records where head will sit once it and its elders are renamed.
            if (w_dp_take) begin
                for (int l = 0; l < C_DP_NUM; l++) begin
                    if (w_dp_en[l]) begin
                        r_snap[w_dp.rob_idx[l]] <= r_head + PTR_W'(w_dp_k[l]) + PTR_W'(w_dp_vld[l]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (w_dp_take) begin
                assert (w_dp_tot <= w_fl.avail_num);
            end
            assert ((w_count + PTR_W'(w_rt_tot)) <= PTR_W'(C_FL_ENTRY));
        end
    end
endmodule

// File: tb/tb_freelist_nway.sv
// Directed and random stimulus for freelist_nway against a reference free-list scoreboard.
module tb_freelist_nway;
    import sys_defs_pkg::*;

    logic                            clk_i = 1'b0;
    logic                            rst_i;
    logic [DP_CNT_W-1:0]             dp_num_i;
    logic [C_DP_NUM-1:0]             dp_rd_nz_i;
    logic [C_DP_NUM-1:0][ROB_W-1:0]  dp_rob_idx_i;
    logic [C_DP_NUM-1:0][PR_W-1:0]   dp_preg_o;
    logic [DP_CNT_W-1:0]             avail_num_o;
    logic [RT_CNT_W-1:0]             rt_num_i;
    logic [C_RT_NUM-1:0][PR_W-1:0]   rt_told_i;
    logic                            rollback_i;
    logic [ROB_W-1:0]                rollback_idx_i;
    logic                            flush_i;
    logic [FL_IDX_W:0]               count_o;

    int checks = 0;
    int failures = 0;

    int m_table [C_FL_ENTRY];
    int m_snap  [C_ROB_ENTRY];
    int m_head, m_tail, m_cmt;
    int sb_q [$];
    int mapped_q [$];
    bit live [C_PR_ENTRY];
    int obs_g [2];

    freelist_nway dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .dp_num_i       (dp_num_i),
        .dp_rd_nz_i     (dp_rd_nz_i),
        .dp_rob_idx_i   (dp_rob_idx_i),
        .dp_preg_o      (dp_preg_o),
        .avail_num_o    (avail_num_o),
        .rt_num_i       (rt_num_i),
        .rt_told_i      (rt_told_i),
        .rollback_i     (rollback_i),
        .rollback_idx_i (rollback_idx_i),
        .flush_i        (flush_i),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        dp_num_i       = '0;
        dp_rd_nz_i     = '0;
        dp_rob_idx_i   = '0;
        rt_num_i       = '0;
        rt_told_i      = '0;
        rollback_i     = 1'b0;
        rollback_idx_i = '0;
        flush_i        = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < C_FL_ENTRY; i++) m_table[i] = C_ARCH_NUM + i;
        for (int i = 0; i < C_ROB_ENTRY; i++) m_snap[i] = 0;
        m_head = 0;
        m_cmt  = 0;
        m_tail = C_FL_ENTRY;
        mapped_q.delete();
        for (int p = 0; p < C_PR_ENTRY; p++) live[p] = 1'b0;
        for (int p = 1; p < C_ARCH_NUM; p++) begin
            live[p] = 1'b1;
            mapped_q.push_back(p);
        end
    endtask

    // Inputs present at the time of the call stay driven through reset.
    task automatic do_reset();
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        clear_inputs();
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("rst_count", count_o, 32'(C_FL_ENTRY));
        chk("rst_avail", avail_num_o, 32'(C_DP_NUM));
        chk("rst_idle_preg0", dp_preg_o[0], 0);
    endtask

    task automatic step(input int dpn, input logic [1:0] nz, input int rob0, input int rob1,
                        input int rtn, input int t0, input int t1,
                        input bit rb, input int rbi, input bit fl);
        int k;
        int rtk;
        int v [2];
        int snapv [2];
        int rob [2];
        int t [2];
        int cnt;
        rob[0] = rob0; rob[1] = rob1;
        t[0] = t0;     t[1] = t1;
        dp_num_i        = DP_CNT_W'(dpn);
        dp_rd_nz_i      = nz;
        dp_rob_idx_i[0] = ROB_W'(rob0);
        dp_rob_idx_i[1] = ROB_W'(rob1);
        rt_num_i        = RT_CNT_W'(rtn);
        rt_told_i[0]    = PR_W'(t0);
        rt_told_i[1]    = PR_W'(t1);
        rollback_i      = rb;
        rollback_idx_i  = ROB_W'(rbi);
        flush_i         = fl;
        k = 0;
        for (int l = 0; l < 2; l++) begin
            v[l] = (l < dpn && nz[l]) ? 1 : 0;
            sb_q.push_back(v[l] != 0 ? m_table[(m_head + k) % C_FL_ENTRY] : 0);
            snapv[l] = m_head + k + v[l];
            k += v[l];
        end
        #1;
        cnt = m_tail - m_head;
        chk("count", count_o, 32'(cnt));
        chk("avail", avail_num_o, 32'(cnt > C_DP_NUM ? C_DP_NUM : cnt));
        for (int l = 0; l < 2; l++) begin
            obs_g[l] = int'(dp_preg_o[l]);
            chk($sformatf("grant_lane%0d", l), dp_preg_o[l], 32'(sb_q.pop_front()));
        end
        rtk = 0;
        for (int l = 0; l < 2; l++) begin
            if (l < rtn && t[l] != 0) begin
                m_table[(m_tail + rtk) % C_FL_ENTRY] = t[l];
                rtk++;
            end
        end
        m_tail += rtk;
        m_cmt  += rtk;
        if (fl) begin
            m_head = m_cmt;
        end else if (rb) begin
            m_head = m_snap[rbi];
        end else begin
            m_head += k;
            for (int l = 0; l < 2; l++) if (l < dpn) m_snap[rob[l]] = snapv[l];
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        int dpn, rtn, av, cnt, room, nv, idx;
        logic [1:0] nz;
        int t [2];

        clear_inputs();
        rst_i = 1'b0;
        do_reset();

        // Two lanes with rd right after reset.
        step(2, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("a_count_after", count_o, 30);
        chk("a_avail_after", avail_num_o, 2);
        step(1, 2'b01, 2, 0, 0, 0, 0, 0, 0, 0);

        // Lane 0 without rd gets preg 0; rollback with ignored dispatch.
        do_reset();
        step(2, 2'b10, 6, 7, 0, 0, 0, 0, 0, 0);
        step(1, 2'b01, 9, 0, 0, 0, 0, 1, 7, 0);
        step(1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0);
        chk("b_count_after", count_o, 30);

        // Drain to empty, then retire with no same-cycle bypass.
        do_reset();
        for (int i = 0; i < 15; i++) step(2, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 2'b01, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("c_avail_one", avail_num_o, 1);
        step(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0);
        chk("c_avail_zero", avail_num_o, 0);
        step(0, 2'b00, 0, 0, 1, 5, 0, 0, 0, 0);
        chk("c_avail_next", avail_num_o, 1);
        step(1, 2'b01, 4, 0, 0, 0, 0, 0, 0, 0);
        chk("c_grant_freed", obs_g[0], 5);

        // Reset while dispatch is being driven.
        dp_num_i = 2'd2;
        dp_rd_nz_i = 2'b11;
        do_reset();

        // Branch rollback to an older snapshot.
        step(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2'b01, 4, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("d_count_head3", count_o, 29);
        step(0, 2'b00, 0, 0, 0, 0, 0, 1, 3, 0);
        chk("d_count_rollback", count_o, 31);
        step(1, 2'b01, 6, 0, 0, 0, 0, 0, 0, 0);
        chk("d_grant_after_rb", obs_g[0], 33);

        // Flush with same-cycle retire, beating a simultaneous rollback.
        do_reset();
        step(2, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0);
        step(2, 2'b11, 2, 3, 0, 0, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 1, 7, 0, 1, 0, 1);
        chk("e_count_flush", count_o, 32);
        for (int i = 0; i < 15; i++) step(2, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0);
        step(2, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("e_wrap_lane0", obs_g[0], 63);
        chk("e_wrap_lane1", obs_g[1], 7);

        // Random dispatch/retire traffic across the wrap point.
        do_reset();
        for (int c = 0; c < 200; c++) begin
            cnt = m_tail - m_head;
            av  = cnt > C_DP_NUM ? C_DP_NUM : cnt;
            dpn = $urandom_range(0, 2);
            nz  = 2'($urandom_range(0, 3));
            nv  = 0;
            for (int l = 0; l < 2; l++) begin
                if (l < dpn && nz[l]) begin
                    if (nv < av) nv++;
                    else nz[l] = 1'b0;
                end
            end
            rtn  = $urandom_range(0, 2);
            t[0] = 0;
            t[1] = 0;
            room = C_FL_ENTRY - cnt;
            for (int l = 0; l < 2; l++) begin
                if (l < rtn && room > 0 && mapped_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    idx = $urandom_range(0, mapped_q.size() - 1);
                    t[l] = mapped_q[idx];
                    mapped_q.delete(idx);
                    live[t[l]] = 1'b0;
                    room--;
                end
            end
            step(dpn, nz, $urandom_range(0, 31), $urandom_range(0, 31),
                 rtn, t[0], t[1], 0, 0, 0);
            for (int l = 0; l < 2; l++) begin
                if (l < dpn && nz[l]) begin
                    chk("rand_unique", 32'(live[obs_g[l] % C_PR_ENTRY]), 0);
                    live[obs_g[l] % C_PR_ENTRY] = 1'b1;
                    mapped_q.push_back(obs_g[l]);
                end
            end
        end
        chk("rand_final_count", count_o, 32'(m_tail - m_head));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
